sm_imem_loader: RTL and testbench

- Boot-time writer for the instruction memory that the CPU fetches from (the CPU drives a word address and reads a 32-bit word).
- Takes a framed byte stream from a host (UART RX, JTAG bridge, testbench) over a valid/ready handshake, assembles 32-bit little-endian words, and writes them to consecutive word addresses starting at 0.
- Holds the CPU in reset until a complete frame with a matching checksum has been written.

---
 rtl/sm_imem_loader_pkg.sv | 28 ++
 rtl/sm_imem_loader.sv | 124 ++++++++++++
 tb/tb_sm_imem_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sm_imem_loader_pkg.sv
// rtl/sm_imem_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
package sm_imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CNT_L = 3'd1,
        CNT_H = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } loaderState_t;

    localparam logic [7:0] DEFAULT_MAGIC  = 8'hA5;
    localparam int         WORD_WIDTH     = 32;
    localparam int         BYTES_PER_WORD = 4;

    // Little-endian assembly: each new byte enters at the top, so after four
    // bytes the first one received sits in bits [7:0].
    function automatic logic [WORD_WIDTH-1:0] shiftInByte(
        input logic [WORD_WIDTH-1:0] word,
        input logic [7:0]            newByte
    );
        return {newByte, word[WORD_WIDTH-1:8]};
    endfunction

endpackage

// File: rtl/sm_imem_loader.sv
// rtl/sm_imem_loader.sv - framed byte-stream loader that fills instruction memory and releases CPU reset
module sm_imem_loader
    import sm_imem_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] MAGIC      = DEFAULT_MAGIC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   im_we,
    output logic [ADDR_WIDTH-1:0]  im_waddr,
    output logic [WORD_WIDTH-1:0]  im_wdata,
    output logic                   cpu_rst_n,
    output logic                   busy,
    output logic                   load_ok,
    output logic                   load_err
);

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    loaderState_t state, nextState;

    logic [7:0]            cntLo;
    logic [15:0]           wordsLeft;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] wordReg;
    logic [1:0]            byteIdx;
    logic [7:0]            sum;

    logic        accept;
    logic        startFrame;
    logic [15:0] frameCount;

    assign accept     = in_valid && in_ready;
    assign frameCount = {in_data, cntLo};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        startFrame = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (accept && in_data == MAGIC) begin
                    nextState  = CNT_L;
                    startFrame = 1'b1;
                end
            end
            CNT_L: begin
                if (accept) nextState = CNT_H;
            end
            CNT_H: begin
                if (accept) begin
                    if ({1'b0, frameCount} > MAX_WORDS) nextState = ERR;
                    else if (frameCount == 16'd0)     nextState = CSUM;
                    else                               nextState = DATA;
                end
            end
            DATA: begin
                if (accept && byteIdx == 2'(BYTES_PER_WORD - 1)) nextState = WRITE;
            end
            WRITE: begin
                nextState = (wordsLeft == 16'd1) ? CSUM : DATA;
            end
            CSUM: begin
                if (accept) nextState = (in_data == sum) ? DONE : ERR;
            end
            default: nextState = IDLE;
        endcase
    end

    // Address, word assembly and checksum; all restart together on a new MAGIC.
    always_ff @(posedge clk) begin
        if (rst) begin
            cntLo     <= '0;
            wordsLeft <= '0;
            addr      <= '0;
            wordReg   <= '0;
            byteIdx   <= '0;
            sum       <= '0;
        end else if (startFrame) begin
            addr    <= '0;
            sum     <= '0;
            byteIdx <= '0;
        end else begin
            case (state)
                CNT_L: if (accept) cntLo <= in_data;
                CNT_H: if (accept) wordsLeft <= frameCount;
                DATA: begin
                    if (accept) begin
                        wordReg <= shiftInByte(wordReg, in_data);
                        sum     <= sum + in_data;
                        byteIdx <= byteIdx + 2'd1;
                    end
                end
                WRITE: begin
                    addr      <= addr + ADDR_WIDTH'(1);
                    wordsLeft <= wordsLeft - 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state != WRITE);
    assign im_we     = (state == WRITE);
    assign im_waddr  = addr;
    assign im_wdata  = wordReg;
    assign cpu_rst_n = (state == DONE);
    assign load_ok   = (state == DONE);
    assign load_err  = (state == ERR);
    assign busy      = (state == CNT_L) || (state == CNT_H) || (state == DATA) ||
                       (state == WRITE) || (state == CSUM);

endmodule

// File: tb/tb_sm_imem_loader.sv
// tb/tb_sm_imem_loader.sv - directed self-checking bench for sm_imem_loader
module tb_sm_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [7:0]  im_waddr;
    logic [31:0] im_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        load_ok;
    logic        load_err;

    int assertCount = 0;
    int failCount   = 0;
    int accepted    = 0;

    logic [7:0]  frame[$];
    logic [7:0]  wAddr[$];
    logic [31:0] wData[$];
    int          lowAt[$];

    sm_imem_loader #(.ADDR_WIDTH(8), .MAGIC(8'hA5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_waddr(im_waddr),
        .im_wdata(im_wdata), .cpu_rst_n(cpu_rst_n), .busy(busy),
        .load_ok(load_ok), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (im_we) begin
                wAddr.push_back(im_waddr);
                wData.push_back(im_wdata);
            end
            if (!in_ready) lowAt.push_back(accepted);
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wordAt(input int i);
        return (wData.size() > i) ? wData[i] : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] addrAt(input int i);
        return (wAddr.size() > i) ? 32'(wAddr[i]) : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] lowAtIdx(input int i);
        return (lowAt.size() > i) ? 32'(lowAt[i]) : 32'hDEADBEEF;
    endfunction

    task automatic clearLogs();
        wAddr.delete();
        wData.delete();
        lowAt.delete();
        accepted = 0;
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic sendByte(input logic [7:0] b, input bit throttle);
        bit taken = 1'b0;
        if (throttle) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data  = 8'hA5;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 8 && !taken; t++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                accepted++;
                taken = 1'b1;
            end
            @(negedge clk);
        end
        if (!taken) checkEq("ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic sendFrame(input bit throttle);
        foreach (frame[i]) sendByte(frame[i], throttle);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkBasicLoad(input string pfx);
        checkEq({pfx, "_nwrites"}, 32'(wData.size()), 32'd2);
        checkEq({pfx, "_addr0"}, addrAt(0), 32'd0);
        checkEq({pfx, "_data0"}, wordAt(0), 32'h24080001);
        checkEq({pfx, "_addr1"}, addrAt(1), 32'd1);
        checkEq({pfx, "_data1"}, wordAt(1), 32'h12345678);
        checkEq({pfx, "_nlow"}, 32'(lowAt.size()), 32'd2);
        checkEq({pfx, "_low0"}, lowAtIdx(0), 32'd7);
        checkEq({pfx, "_low1"}, lowAtIdx(1), 32'd11);
        checkEq({pfx, "_load_ok"}, 32'(load_ok), 32'd1);
        checkEq({pfx, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
        checkEq({pfx, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkEq({pfx, "_in_ready"}, 32'(in_ready), 32'd1);
        checkEq({pfx, "_im_we"}, 32'(im_we), 32'd0);
        checkEq({pfx, "_im_waddr"}, 32'(im_waddr), 32'd0);
        checkEq({pfx, "_im_wdata"}, im_wdata, 32'd0);
        checkEq({pfx, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        checkEq({pfx, "_busy"}, 32'(busy), 32'd0);
        checkEq({pfx, "_load_ok"}, 32'(load_ok), 32'd0);
        checkEq({pfx, "_load_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("rst");
        rst = 1'b0;
        clearLogs();

        // Data bytes 01 00 08 24 78 56 34 12 sum to 0x141, so CSUM = 0x41.
        frame = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h08, 8'h24,
                  8'h78, 8'h56, 8'h34, 8'h12, 8'h41};
        sendFrame(1'b0);
        checkBasicLoad("basic");

        clearLogs();
        sendByte(8'hA5, 1'b0);
        checkEq("restart_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkEq("restart_busy", 32'(busy), 32'd1);
        frame = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h08, 8'h24,
                  8'h78, 8'h56, 8'h34, 8'h12, 8'h40};
        sendFrame(1'b0);
        checkEq("badsum_nwrites", 32'(wData.size()), 32'd2);
        checkEq("badsum_data1", wordAt(1), 32'h12345678);
        checkEq("badsum_load_err", 32'(load_err), 32'd1);
        checkEq("badsum_load_ok", 32'(load_ok), 32'd0);
        checkEq("badsum_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        clearLogs();
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        sendFrame(1'b0);
        checkEq("empty_after_err_load_ok", 32'(load_ok), 32'd1);
        checkEq("empty_after_err_nwrites", 32'(wData.size()), 32'd0);

        clearLogs();
        frame = '{8'hA5, 8'h01, 8'h01};
        sendFrame(1'b0);
        checkEq("ovf_load_err", 32'(load_err), 32'd1);
        checkEq("ovf_busy", 32'(busy), 32'd0);
        frame = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        sendFrame(1'b0);
        checkEq("ovf_nwrites", 32'(wData.size()), 32'd0);
        checkEq("ovf_still_err", 32'(load_err), 32'd1);

        doReset();
        rst = 1'b0;
        clearLogs();
        frame = '{8'h00, 8'hFF};
        sendFrame(1'b0);
        checkEq("noise_busy", 32'(busy), 32'd0);
        checkEq("noise_load_ok", 32'(load_ok), 32'd0);
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        sendFrame(1'b0);
        checkEq("zero_load_ok", 32'(load_ok), 32'd1);
        checkEq("zero_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        checkEq("zero_nwrites", 32'(wData.size()), 32'd0);

        // N = 256 is the largest legal count; then abort it mid-word.
        clearLogs();
        frame = '{8'hA5, 8'h00, 8'h01, 8'hAA, 8'hBB};
        sendFrame(1'b0);
        checkEq("max_cnt_busy", 32'(busy), 32'd1);
        checkEq("max_cnt_load_err", 32'(load_err), 32'd0);
        doReset();
        checkResetOutputs("midrst");
        rst = 1'b0;
        clearLogs();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h08, 8'h24,
                  8'h78, 8'h56, 8'h34, 8'h12, 8'h41};
        sendFrame(1'b0);
        checkBasicLoad("after_rst");

        doReset();
        rst = 1'b0;
        clearLogs();
        sendFrame(1'b1);
        checkBasicLoad("throttled");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
